// File: rtl/qoi_buffer_engine_port.sv
// Port-B sequencer for the QOI double-buffer memory: streams the input buffer to the
// codec through a 2-entry skid FIFO while writing codec results into the output buffer.
module qoi_buffer_engine_port #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   out_count,
    output logic              sel,
    output logic [ADDR_W-1:0] addr_b,
    output logic [7:0]        data_b_i,
    input  logic [7:0]        data_b_o,
    output logic              cs_b,
    output logic              we_b,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_pend_last_q, rd_pend_last_d;
    logic [1:0][7:0]   fifo_data_q, fifo_data_d;
    logic [1:0]        fifo_last_q, fifo_last_d;
    logic              fifo_head_q, fifo_head_d;
    logic              fifo_tail_q, fifo_tail_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W:0]   out_count_q, out_count_d;

    logic              run;
    logic              pop;
    logic              push;
    logic              wr_fire;
    logic              rd_fire;
    logic [2:0]        occ;

    always_comb begin
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        fifo_data_d    = fifo_data_q;
        fifo_last_d    = fifo_last_q;
        fifo_head_d    = fifo_head_q;
        fifo_tail_d    = fifo_tail_q;
        overflow_d     = overflow_q;
        out_count_d    = out_count_q;

        run      = (state_q == RUN);
        s_ready  = run && !wr_ptr_q[ADDR_W];
        m_valid  = run && (fifo_cnt_q != 2'd0);
        m_data   = fifo_data_q[fifo_head_q];
        m_last   = m_valid && fifo_last_q[fifo_head_q];
        pop      = m_valid && m_ready;
        push     = run && rd_pend_q;
        wr_fire  = s_valid && s_ready;

        // Reads in flight count against the FIFO so a landing byte always has a slot.
        occ      = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        rd_fire  = run && !wr_fire && !rd_ptr_q[ADDR_W] && (occ < 3'd2);

        cs_b     = wr_fire || rd_fire;
        we_b     = wr_fire;
        addr_b   = '0;
        data_b_i = 8'h00;
        if (wr_fire) begin
            addr_b   = wr_ptr_q[ADDR_W-1:0];
            data_b_i = s_data;
        end else if (rd_fire) begin
            addr_b   = rd_ptr_q[ADDR_W-1:0];
        end

        if (pop) begin
            fifo_head_d = ~fifo_head_q;
        end
        if (push) begin
            fifo_data_d[fifo_tail_q] = data_b_o;
            fifo_last_d[fifo_tail_q] = rd_pend_last_q;
            fifo_tail_d              = ~fifo_tail_q;
        end
        fifo_cnt_d     = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        rd_pend_d      = rd_fire;
        rd_pend_last_d = (rd_ptr_q == LAST_IDX);
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                    rd_pend_d   = 1'b0;
                    fifo_head_d = 1'b0;
                    fifo_tail_d = 1'b0;
                    fifo_cnt_d  = 2'd0;
                    overflow_d  = 1'b0;
                    out_count_d = '0;
                end
            end
            RUN: begin
                // The final write (last byte or the one that fills the buffer) ends the pass.
                if (wr_fire && (s_last || (wr_ptr_q == LAST_IDX))) begin
                    state_d     = DONE;
                    out_count_d = wr_ptr_q + PTR_ONE;
                    overflow_d  = !s_last;
                    rd_pend_d   = 1'b0;
                    fifo_head_d = 1'b0;
                    fifo_tail_d = 1'b0;
                    fifo_cnt_d  = 2'd0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            fifo_data_q    <= '0;
            fifo_last_q    <= '0;
            fifo_head_q    <= 1'b0;
            fifo_tail_q    <= 1'b0;
            fifo_cnt_q     <= 2'd0;
            overflow_q     <= 1'b0;
            out_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_pend_q      <= rd_pend_d;
            rd_pend_last_q <= rd_pend_last_d;
            fifo_data_q    <= fifo_data_d;
            fifo_last_q    <= fifo_last_d;
            fifo_head_q    <= fifo_head_d;
            fifo_tail_q    <= fifo_tail_d;
            fifo_cnt_q     <= fifo_cnt_d;
            overflow_q     <= overflow_d;
            out_count_q    <= out_count_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sel       = run;
    assign overflow  = overflow_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_qoi_buffer_engine_port.sv
// Randomized directed passes for qoi_buffer_engine_port against a behavioural model of
// the byte streams, the buffer contents and the pass result.
module tb_qoi_buffer_engine_port;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int MAXC   = 300;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, done, overflow;
    logic [ADDR_W:0]   out_count;
    logic              sel;
    logic [ADDR_W-1:0] addr_b;
    logic [7:0]        data_b_i;
    logic [7:0]        data_b_o;
    logic              cs_b, we_b;
    logic [7:0]        m_data;
    logic              m_valid, m_ready, m_last;
    logic [7:0]        s_data;
    logic              s_valid, s_ready, s_last;

    logic [7:0] inMem  [DEPTH];
    logic [7:0] outMem [DEPTH];

    int checks   = 0;
    int failures = 0;

    qoi_buffer_engine_port #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .out_count (out_count),
        .sel       (sel),
        .addr_b    (addr_b),
        .data_b_i  (data_b_i),
        .data_b_o  (data_b_o),
        .cs_b      (cs_b),
        .we_b      (we_b),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM pair: registered read from the input buffer, write to the output buffer.
    always @(posedge clk) begin
        if (cs_b && !we_b) data_b_o <= inMem[addr_b];
        if (cs_b && we_b)  outMem[addr_b] <= data_b_i;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the falling edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic st, input logic mr, input logic sv,
                                 input logic [7:0] sd, input logic sl);
        @(negedge clk);
        start   = st;
        m_ready = mr;
        s_valid = sv;
        s_data  = sd;
        s_last  = sl;
        #1;
    endtask

    task automatic checkResetOutputs(input string phase);
        checkOutput({phase, "_sel"},       32'(sel),       32'd0);
        checkOutput({phase, "_cs_b"},      32'(cs_b),      32'd0);
        checkOutput({phase, "_we_b"},      32'(we_b),      32'd0);
        checkOutput({phase, "_busy"},      32'(busy),      32'd0);
        checkOutput({phase, "_done"},      32'(done),      32'd0);
        checkOutput({phase, "_overflow"},  32'(overflow),  32'd0);
        checkOutput({phase, "_out_count"}, 32'(out_count), 32'd0);
        checkOutput({phase, "_m_valid"},   32'(m_valid),   32'd0);
        checkOutput({phase, "_s_ready"},   32'(s_ready),   32'd0);
    endtask

    // mrMode: 0 always ready, 1 pattern 1,0,0, 2 random.
    // sMode: 0 echo received bytes, 1 random writes, 2 four-cycle burst then random.
    // lastAt: write number carrying s_last (0 = never). abortAt: cycle of a mid-pass reset.
    task automatic runPass(input int mrMode, input int sMode, input int lastAt, input int abortAt);
        logic [7:0] echoQ[$];
        logic [7:0] sentQ[$];
        int expIdx = 0;
        int readIdx = 0;
        int wrCount = 0;
        int firstValid = -1;
        bit term = 1'b0;
        bit prevStall = 1'b0;
        logic [7:0] prevData = 8'h00;
        logic prevLast = 1'b0;
        logic mr, sv, sl;
        logic [7:0] sd;
        int expCount;

        for (int i = 0; i < DEPTH; i++) outMem[i] = 8'($urandom);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("idle_busy_at_start", 32'(busy), 32'd0);

        for (int cyc = 1; cyc <= MAXC && !term; cyc++) begin
            case (mrMode)
                0:       mr = 1'b1;
                1:       mr = ((cyc % 3) == 1);
                default: mr = 1'($urandom_range(0, 1));
            endcase
            case (sMode)
                0: begin
                    sv = (echoQ.size() > 0);
                    sd = sv ? echoQ[0] : 8'h00;
                end
                1: begin
                    sv = 1'($urandom_range(0, 1));
                    sd = 8'($urandom);
                end
                default: begin
                    sv = (cyc >= 2 && cyc <= 5) || (cyc > 8 && $urandom_range(0, 2) == 0);
                    sd = 8'($urandom);
                end
            endcase
            sl = sv && (wrCount + 1 == lastAt);
            applyStimulus(1'($urandom_range(0, 1)), mr, sv, sd, sl);

            if (cyc == abortAt) begin
                rst = 1'b0;
                #1;
                checkResetOutputs("midrun_reset");
                @(negedge clk);
                start = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
                rst = 1'b1;
                applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
                checkOutput("post_reset_idle", 32'(busy), 32'd0);
                return;
            end

            if (cyc == 1) begin
                checkOutput("run_sel", 32'(sel), 32'd1);
                checkOutput("run_busy", 32'(busy), 32'd1);
                if (!sv) checkOutput("first_read_cs", 32'(cs_b), 32'd1);
            end
            checkOutput("done_low_in_run", 32'(done), 32'd0);
            checkOutput("s_ready_in_run", 32'(s_ready), 32'd1);
            if (m_valid && firstValid < 0) firstValid = cyc;

            if (prevStall) begin
                checkOutput("stall_valid", 32'(m_valid), 32'd1);
                checkOutput("stall_data", 32'(m_data), 32'(prevData));
                checkOutput("stall_last", 32'(m_last), 32'(prevLast));
            end

            if (m_valid && m_ready) begin
                if (expIdx < DEPTH) begin
                    checkOutput("m_data_order", 32'(m_data), 32'(inMem[expIdx]));
                    checkOutput("m_last_flag", 32'(m_last), 32'(expIdx == DEPTH - 1));
                end else begin
                    checkOutput("m_extra_byte", 32'(expIdx), 32'(DEPTH - 1));
                end
                expIdx++;
                if (sMode == 0) echoQ.push_back(m_data);
            end

            if (sv && s_ready) begin
                checkOutput("wr_cs", 32'(cs_b), 32'd1);
                checkOutput("wr_we", 32'(we_b), 32'd1);
                checkOutput("wr_addr", 32'(addr_b), 32'(wrCount % DEPTH));
                checkOutput("wr_data", 32'(data_b_i), 32'(sd));
                sentQ.push_back(sd);
                wrCount++;
                if (sMode == 0) void'(echoQ.pop_front());
                if (sl || wrCount == DEPTH) term = 1'b1;
            end else if (cs_b) begin
                checkOutput("rd_we", 32'(we_b), 32'd0);
                checkOutput("rd_addr", 32'(addr_b), 32'(readIdx));
                readIdx++;
            end

            prevStall = m_valid && !m_ready;
            prevData  = m_data;
            prevLast  = m_last;
        end

        if (!term) begin
            checkOutput("pass_timeout", 32'd0, 32'd1);
            return;
        end

        expCount = (lastAt != 0) ? lastAt : DEPTH;
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("done_sel", 32'(sel), 32'd0);
        checkOutput("done_s_ready", 32'(s_ready), 32'd0);
        checkOutput("done_m_valid", 32'(m_valid), 32'd0);
        checkOutput("done_cs_b", 32'(cs_b), 32'd0);
        checkOutput("done_busy", 32'(busy), 32'd1);
        checkOutput("out_count", 32'(out_count), 32'(expCount));
        checkOutput("overflow", 32'(overflow), 32'(lastAt == 0));

        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("after_done_busy", 32'(busy), 32'd0);
        checkOutput("after_done_done", 32'(done), 32'd0);
        checkOutput("held_out_count", 32'(out_count), 32'(expCount));
        checkOutput("held_overflow", 32'(overflow), 32'(lastAt == 0));

        for (int i = 0; i < wrCount; i++) begin
            checkOutput($sformatf("out_mem_%0d", i), 32'(outMem[i]), 32'(sentQ[i]));
        end
        if (sMode == 0 && lastAt == DEPTH) begin
            checkOutput("all_bytes_sent", 32'(expIdx), 32'(DEPTH));
        end
        if (mrMode == 0 && sMode == 0) begin
            checkOutput("first_m_valid_cycle", 32'(firstValid), 32'd3);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; m_ready = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        data_b_o = 8'h00;
        for (int i = 0; i < DEPTH; i++) inMem[i] = 8'(i);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkResetOutputs("por");
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] echo pass");
        runPass(0, 0, DEPTH, 0);

        $display("[TB] backpressure pass");
        for (int i = 0; i < DEPTH; i++) inMem[i] = 8'($urandom);
        runPass(1, 0, DEPTH, 0);

        $display("[TB] write priority pass");
        for (int i = 0; i < DEPTH; i++) inMem[i] = 8'($urandom);
        runPass(2, 2, 10, 0);

        $display("[TB] early last pass");
        runPass(2, 0, 3, 0);

        $display("[TB] overflow pass");
        runPass(2, 1, 0, 0);

        $display("[TB] mid-run reset then fresh pass");
        for (int i = 0; i < DEPTH; i++) inMem[i] = 8'($urandom);
        runPass(0, 1, 0, 6);
        runPass(0, 0, DEPTH, 0);

        $display("[TB] random echo pass");
        runPass(2, 0, DEPTH, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qoi_buffer_engine_port.md
# qoi_buffer_engine_port

Port-B sequencer for the QOI double-buffer memory unit. On a start request it takes buffer ownership by driving `sel` high, then streams the input buffer out to the codec core byte by byte. In parallel it writes the codec's result bytes into the output buffer, then hands ownership back to the 6502 side and reports the result length. It is the codec-side counterpart of the CPU-side (port A) access path.

## Interface

**Parameters**
- `ADDR_W`, default 8: buffer address width; `DEPTH = 2**ADDR_W` bytes per buffer.

**Ports**
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin a pass. Ignored unless `busy` = 0.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse at the end of a pass.
- `overflow` out 1: set when the output buffer filled without a last byte. Held until the next accepted `start`.
- `out_count` out ADDR_W+1: number of bytes written to the output buffer in the last pass. Held until the next accepted `start`.
- `sel` out 1: buffer ownership; 1 = port B owns both buffers.
- `addr_b` out ADDR_W: port-B address.
- `data_b_i` out 8: write data to the output buffer.
- `data_b_o` in 8: read data from the input buffer.
- `cs_b` out 1: port-B access strobe.
- `we_b` out 1: 1 = write to the output buffer, 0 = read from the input buffer.
- `m_data` out 8, `m_valid` out 1, `m_ready` in 1, `m_last` out 1: input-byte stream to the codec.
- `s_data` in 8, `s_valid` in 1, `s_ready` out 1, `s_last` in 1: result-byte stream from the codec.

## Operation

- **States.**
  - IDLE: `sel` = 0, `cs_b` = 0, `s_ready` = 0, `m_valid` = 0.
  - RUN: `sel` = 1 and port-B accesses are issued.
  - DONE: lasts one cycle; `sel` = 0, `done` = 1. Returns to IDLE.
- **IDLE → RUN.** On `start`: clear `rd_ptr`, `wr_ptr` (both ADDR_W+1 bits), the skid FIFO, `overflow` and `out_count`.
- **Port-B arbitration in RUN** (one access per cycle):
  - Write has priority. If `s_valid && s_ready`, drive `cs_b` = 1, `we_b` = 1, `addr_b` = `wr_ptr[ADDR_W-1:0]`, `data_b_i` = `s_data`, then increment `wr_ptr`.
  - Otherwise, issue a read when `rd_ptr < DEPTH` and (FIFO occupancy + reads in flight − pop this cycle) < 2. Drive `cs_b` = 1, `we_b` = 0, `addr_b` = `rd_ptr`, then increment `rd_ptr`.
  - Otherwise, `cs_b` = 0.
- **Read path.** SRAM read data is valid on `data_b_o` the cycle after issue. It is captured into a 2-entry skid FIFO at the end of that cycle.
  - `m_valid` = FIFO not empty; `m_data` = FIFO head.
  - `m_last` = 1 when the head is byte `DEPTH-1`.
  - A pop occurs on `m_valid && m_ready`.
- **Write path.** `s_ready` = 1 in RUN while `wr_ptr < DEPTH`.
- **Termination.**
  - An accepted write with `s_last` = 1 goes to DONE, with `out_count` = `wr_ptr` + 1. Unread and unsent input bytes are discarded and the FIFO is flushed.
  - If `wr_ptr` reaches `DEPTH` with no last byte: set `overflow`, set `out_count` = `DEPTH`, go to DONE.
  - Exhausting the input does not end the pass; only the codec's last byte or overflow does.
- **Ordering.** Bytes leave on `m_*` in strictly ascending address order, each exactly once. A stalled read stream never reorders or drops data.
- **Reset.** `rst` low at any time, including mid-RUN, immediately forces:
  - IDLE, with `sel` = 0, `cs_b` = 0, `we_b` = 0;
  - `busy` = 0, `done` = 0, `overflow` = 0, `out_count` = 0;
  - `m_valid` = 0, `s_ready` = 0, FIFO empty.
  - Buffer contents are not touched.

## Timing

- Cycle 0: `start` sampled. Cycle 1: RUN, `sel` = 1, `busy` = 1, read of address 0 issued.
- Cycle 2: `data_b_o` is valid and captured. Cycle 3: first `m_valid` = 1.
- Sustained read throughput: 1 byte/cycle with `m_ready` held high and no writes. Each accepted write costs one read slot.
- `m_data`/`m_last` stay stable while `m_valid && !m_ready`.
- The accepted last write (or the overflowing write) occurs in cycle N. In cycle N+1: DONE, `done` = 1, `sel` = 0, `s_ready` = 0, `m_valid` = 0. In cycle N+2: IDLE, `busy` = 0.
- `start` asserted during RUN or DONE is ignored.

## Test plan

- **Reset.** Pull `rst` low mid-cycle during RUN → all outputs listed under Reset take their reset values before the next edge; `start` 2 cycles after release begins a fresh pass with `rd_ptr` = 0.
- **Echo pass** (ADDR_W = 4). Input buffer preloaded 0x00..0x0F; codec echoes with `m_ready` = 1 and `s_last` on the 16th byte → output buffer = 0x00..0x0F, `out_count` = 16, `overflow` = 0, first `m_valid` at cycle 3, `done` pulse exactly once.
- **Backpressure.** `m_ready` toggled 1,0,0,1… → all 16 bytes are delivered once in order; `m_data` is held during stalls; `m_last` coincides only with byte 0x0F.
- **Write priority.** `s_valid` held high for 4 cycles while reads are pending → 4 consecutive `cs_b`/`we_b` = 1 accesses at addresses 0..3; reads resume afterwards with no skipped address.
- **Early last.** `s_last` on the 3rd accepted write → `out_count` = 3, DONE on the next cycle, `m_valid` = 0 and `sel` = 0 thereafter.
- **Overflow.** 16 writes without `s_last` → `overflow` = 1, `out_count` = 16, `s_ready` = 0 afterwards, `done` pulse.
